// File: rtl/tick_scheduler.sv
// tick_scheduler: a bank of programmable divider channels. Each channel emits a tick strobe
// and a 50%-duty divided clock; reconfiguration is deferred to period boundaries.
module tick_scheduler #(
    parameter int CH      = 4,
    parameter int W       = 26,
    parameter int DEF_DIV = 24991
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0]  cfg_ch,
    input  logic [W-1:0]                            cfg_div,
    input  logic                                    cfg_en,
    output logic [CH-1:0]                           tick_o,
    output logic [CH-1:0]                           clk_o,
    output logic                                    busy
);

    localparam int           CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] DEF = W'(DEF_DIV);

    typedef struct packed {
        logic [W-1:0] cnt;
        logic [W-1:0] div;
        logic [W-1:0] pdiv;
        logic         en;
        logic         pen;
        logic         pend;
        logic         tick;
        logic         clko;
    } ch_state_t;

    localparam ch_state_t RESET_STATE = '{
        cnt:  '0,
        div:  DEF,
        pdiv: DEF,
        en:   1'b1,
        pen:  1'b1,
        pend: 1'b0,
        tick: 1'b0,
        clko: 1'b0
    };

    logic [CH-1:0] pend_vec;

    // Channel numbers beyond the bank are always ready; their writes are simply dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                cfg_ready = ~pend_vec[i];
            end
        end
    end

    assign busy = |pend_vec;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        ch_state_t cur;
        ch_state_t nxt;
        logic      accept;
        logic      boundary;

        assign accept   = cfg_valid & ~cur.pend & (cfg_ch == CHW'(g));
        assign boundary = cur.en & (cur.cnt == cur.div - ONE);

        always_comb begin
            // NOTE: every field starts from its held value so no branch can infer a latch.
            nxt = cur;
            if (cur.en) begin
                if (boundary) begin
                    nxt.cnt  = '0;
                    nxt.tick = 1'b1;
                    nxt.clko = ~cur.clko;
                    if (cur.pend) begin
                        nxt.div = cur.pdiv;
                        // A disable lands only on a falling edge, so the high phase is never cut.
                        if (cur.pen || cur.clko) begin
                            nxt.en   = cur.pen;
                            nxt.pend = 1'b0;
                        end
                    end
                end else begin
                    nxt.cnt  = cur.cnt + ONE;
                    nxt.tick = 1'b0;
                end
            end else begin
                nxt.cnt  = '0;
                nxt.tick = 1'b0;
                nxt.clko = 1'b0;
                if (cur.pend) begin
                    nxt.div  = cur.pdiv;
                    nxt.en   = cur.pen;
                    nxt.pend = 1'b0;
                end
            end

            // Acceptance needs pend clear, so it never collides with an apply above.
            if (accept) begin
                nxt.pdiv = (cfg_div == '0) ? ONE : cfg_div;
                nxt.pen  = cfg_en;
                nxt.pend = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            // NOTE: sequential state uses non-blocking assignment so all channels update together.
            if (!rst) begin
                cur <= RESET_STATE;
            end else begin
                cur <= nxt;
            end
        end

        assign tick_o[g]   = cur.tick;
        assign clk_o[g]    = cur.clko;
        assign pend_vec[g] = cur.pend;
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios plus random config traffic, checked against a
// schedule model that tracks each channel's next boundary as an absolute edge number.
module tb_tick_scheduler;

    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int DEF = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [W-1:0]  cfg_div;
    logic          cfg_en;
    logic [CH-1:0] tick_o;
    logic [CH-1:0] clk_o;
    logic          busy;

    logic          oor_valid;
    logic          oor_ready;
    logic [2:0]    oor_ch;
    logic [W-1:0]  oor_div;
    logic          oor_en;
    logic [4:0]    oor_tick;
    logic [4:0]    oor_clk;
    logic          oor_busy;

    int checks;
    int errors;

    // Model state: edge count since reset release and per-channel schedule.
    int n;
    int m_en[CH];
    int m_div[CH];
    int m_level[CH];
    int m_next[CH];
    int m_pend[CH];
    int m_pdiv[CH];
    int m_pen[CH];
    int m_tick[CH];

    logic acc_dummy;

    always #5 clk = ~clk;

    tick_scheduler #(.CH(CH), .W(W), .DEF_DIV(DEF)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .tick_o    (tick_o),
        .clk_o     (clk_o),
        .busy      (busy)
    );

    // Five channels give a 3-bit channel field, so codes 5..7 are genuinely out of range.
    tick_scheduler #(.CH(5), .W(W), .DEF_DIV(DEF)) u_oor (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (oor_valid),
        .cfg_ready (oor_ready),
        .cfg_ch    (oor_ch),
        .cfg_div   (oor_div),
        .cfg_en    (oor_en),
        .tick_o    (oor_tick),
        .clk_o     (oor_clk),
        .busy      (oor_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_en[i]    = 1;
            m_div[i]   = DEF;
            m_level[i] = 0;
            m_next[i]  = DEF;
            m_pend[i]  = 0;
            m_pdiv[i]  = DEF;
            m_pen[i]   = 1;
            m_tick[i]  = 0;
        end
        n = 0;
    endtask

    // Advance the model by one rising edge; rdy is the handshake seen before that edge.
    task automatic model_edge(input logic v, input int ch, input int d, input logic e,
                              input logic rdy);
        int old;
        n++;
        for (int i = 0; i < CH; i++) begin
            if (m_en[i] != 0) begin
                if (n == m_next[i]) begin
                    old        = m_level[i];
                    m_tick[i]  = 1;
                    m_level[i] = 1 - old;
                    if (m_pend[i] != 0) begin
                        m_div[i] = m_pdiv[i];
                        if (m_pen[i] != 0 || old == 1) begin
                            m_en[i]   = m_pen[i];
                            m_pend[i] = 0;
                        end
                    end
                    m_next[i] = n + m_div[i];
                end else begin
                    m_tick[i] = 0;
                end
            end else begin
                m_tick[i]  = 0;
                m_level[i] = 0;
                if (m_pend[i] != 0) begin
                    m_div[i]  = m_pdiv[i];
                    m_en[i]   = m_pen[i];
                    m_pend[i] = 0;
                    m_next[i] = n + m_div[i];
                end
            end
            if (v && rdy && ch == i) begin
                m_pdiv[i] = (d == 0) ? 1 : d;
                m_pen[i]  = int'(e);
                m_pend[i] = 1;
            end
        end
    endtask

    function automatic logic [CH-1:0] exp_tick();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = (m_tick[i] != 0);
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_clk();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) r[i] = (m_level[i] != 0);
        return r;
    endfunction

    function automatic logic exp_busy();
        logic r;
        r = 1'b0;
        for (int i = 0; i < CH; i++) r = r | (m_pend[i] != 0);
        return r;
    endfunction

    // One clock: drive after the falling edge, check ready, take the edge, check outputs.
    task automatic do_cycle(input logic v, input int ch, input int d, input logic e,
                            output logic acc);
        logic       rdy;
        logic [4:0] o_t;
        logic [4:0] o_c;
        cfg_valid = v;
        cfg_ch    = 2'(ch);
        cfg_div   = 8'(d);
        cfg_en    = e;
        oor_valid = 1'($urandom);
        oor_ch    = 3'(5 + $urandom_range(0, 2));
        oor_div   = 8'($urandom);
        oor_en    = 1'($urandom);
        #1;
        rdy = (m_pend[ch] == 0);
        check("cfg_ready", 32'(cfg_ready), 32'(rdy));
        check("oor_ready", 32'(oor_ready), 32'(1));
        acc = v && rdy;
        @(posedge clk);
        model_edge(v, ch, d, e, rdy);
        @(negedge clk);
        check("tick_o", 32'(tick_o), 32'(exp_tick()));
        check("clk_o", 32'(clk_o), 32'(exp_clk()));
        check("busy", 32'(busy), 32'(exp_busy()));
        o_t = (n > 0 && n % DEF == 0) ? 5'h1f : 5'h00;
        o_c = ((n / DEF) % 2 == 1) ? 5'h1f : 5'h00;
        check("oor_tick", 32'(oor_tick), 32'(o_t));
        check("oor_clk", 32'(oor_clk), 32'(o_c));
        check("oor_busy", 32'(oor_busy), 32'(0));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) do_cycle(1'b0, 0, 0, 1'b0, acc_dummy);
    endtask

    // Hold a write until it is accepted, bounded so a stuck ready still ends the run.
    task automatic send(input int ch, input int d, input logic e);
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 64) begin
            do_cycle(1'b1, ch, d, e, acc);
            k++;
        end
        check("send_accepted", 32'(acc), 32'(1));
        cfg_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;
        oor_valid = 1'b0;
        oor_ch    = '0;
        oor_div   = '0;
        oor_en    = 1'b0;
        model_reset();

        // Reset state.
        #2;
        check("rst_tick", 32'(tick_o), 32'(0));
        check("rst_clk_o", 32'(clk_o), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ready", 32'(cfg_ready), 32'(1));
        check("rst_oor_busy", 32'(oor_busy), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset release: ticks on edges 4, 8, 12...
        idle(21);

        // Divisor change on ch1 at cnt=1, a write to another channel, then a stalled rewrite.
        send(1, 2, 1'b1);
        send(3, 4, 1'b1);
        send(1, 2, 1'b1);
        idle(12);

        // Zero divisor on ch0 behaves as divisor 1.
        send(0, 0, 1'b1);
        idle(12);

        // Disable ch2 while its clock is low, then re-enable with divisor 3.
        k = 0;
        while (m_level[2] != 0 && k < 16) begin
            do_cycle(1'b0, 0, 0, 1'b0, acc_dummy);
            k++;
        end
        send(2, 4, 1'b0);
        idle(20);
        send(2, 3, 1'b1);
        idle(12);

        // Reset mid-operation with ch3 high and a pending update.
        k = 0;
        while (!(m_level[3] == 1 && m_next[3] > n + 2) && k < 40) begin
            do_cycle(1'b0, 0, 0, 1'b0, acc_dummy);
            k++;
        end
        send(3, 5, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("async_tick", 32'(tick_o), 32'(0));
        check("async_clk_o", 32'(clk_o), 32'(0));
        check("async_busy", 32'(busy), 32'(0));
        check("async_oor_clk", 32'(oor_clk), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check("held_clk_o", 32'(clk_o), 32'(0));
        check("held_busy", 32'(busy), 32'(0));
        rst = 1'b1;
        model_reset();
        idle(20);

        // Random configuration traffic.
        for (int i = 0; i < 600; i++) begin
            do_cycle(($urandom % 3) == 0, int'($urandom % 4), int'($urandom % 8),
                     ($urandom % 4) != 0, acc_dummy);
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
